inst_sequencer: RTL
===================

// Module: inst_sequencer
// PURPOSE
//  Feeds a bounded, legal instruction stream into the ridecore fetch port for Coppelia BMC and simulation.
//  Buffers source instructions, issues them under core backpressure and pads bubbles with NOPs.
//  Ends each run with a NOP drain window so in-flight instructions retire before checking.
//  Sits between the instruction source (symbolic or bench) and the core instruction input.
// PARAMETERS
//  DEPTH         4   FIFO entries, power of 2, >=2
//  MAX_INSTS     8   real instructions accepted per run, >=1
//  DRAIN_CYCLES  16  non-stalled NOP cycles issued after the last real instruction, >=1
// PORTS
//  clk           in   1   clock, rising edge
//  reset         in   1   asynchronous, active-high reset
//  start         in   1   begin a run; sampled in IDLE/DONE only
//  src_valid     in   1   source instruction valid
//  src_inst      in   32  source instruction
//  src_ready     out  1   sequencer accepts src_inst this cycle
//  fetch_stall   in   1   core cannot take out_inst this cycle
//  out_valid     out  1   out_inst presented to the core
//  out_inst      out  32  instruction to fetch (NOP = 32'h0000007F)
//  issued_cnt    out  CW  real instructions issued this run; CW=$clog2(MAX_INSTS+1)
//  busy          out  1   state is RUN or DRAIN
//  done          out  1   state is DONE
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, FIFO empty, all counters 0.
//    Reset outputs: src_ready=0, out_valid=0, out_inst=NOP, issued_cnt=0, busy=0, done=0.
//  - FSM states and transitions:
//    IDLE  -> RUN when start=1.
//    RUN   -> DRAIN when accepted_cnt==MAX_INSTS and the FIFO is empty after this cycle's pop.
//    DRAIN -> DONE when drain_cnt reaches DRAIN_CYCLES.
//    DONE  -> RUN when start=1; entry clears issued_cnt, accepted_cnt and drain_cnt.
//  - start is ignored while in RUN or DRAIN.
//  - Push: src_ready = (state==RUN) && !full && accepted_cnt<MAX_INSTS.
//    Push occurs on src_valid&&src_ready; accepted_cnt increments on each push.
//  - src_ready has no combinational path from pop or fetch_stall; push is blocked while full, even if a pop occurs in the same cycle.
//  - Output: out_valid=1 in RUN and DRAIN, 0 in IDLE and DONE.
//    In RUN with a non-empty FIFO, out_inst = FIFO head; otherwise out_inst = NOP.
//    out_inst and out_valid are combinational from the FIFO head and state.
//  - Pop: in RUN when !empty && !fetch_stall; issued_cnt increments on each pop.
//    NOP bubbles are never counted.
//  - Simultaneous push and pop when not full: both occur; occupancy is unchanged.
//  - Stall: out_inst and the FIFO head are held while fetch_stall=1.
//  - drain_cnt increments only on DRAIN cycles with fetch_stall=0.
//  - MAX_INSTS and DRAIN_CYCLES counters saturate and never wrap.
//  - FIFO pointers wrap modulo DEPTH; full/empty use an extra wrap bit.
//  - Reset mid-run discards FIFO contents and returns to IDLE.
// CONFIGURATION
//  INST_LEGALITY_CHECK_EN defined:
//   - Each pushed instruction is checked against the supported subset:
//     RV32I R-type ALU and M multiplies (MUL/MULH/MULHSU/MULHU), I-type ALU and shifts,
//     LW/SW with rs1=x0 and imm[11:10]=0, NOP opcode 7'h7F. Register indices must be <16.
//   - An illegal instruction is still handshaked (consumes src_ready and accepted_cnt)
//     but is replaced by NOP in the FIFO and is not counted by issued_cnt.
//   - Adds output illegal_seen (1 bit): sticky per run, cleared on reset and on RUN entry.
//  INST_LEGALITY_CHECK_EN undefined: every instruction passes unmodified; no illegal_seen port.
// STRUCTURE
//  - Package inst_seq_pkg: NOP_INST, opcode/funct3/funct7 constants, state enum
//    (IDLE, RUN, DRAIN, DONE) and the legality function.
//  - Sub-module inst_seq_fifo: DEPTH-entry 32-bit synchronous FIFO with async reset,
//    push/pop/full/empty. The FSM and counters stay in the top module.
// TESTING
//  - Reset mid-DRAIN -> next cycle out_valid=0, out_inst=32'h7F, busy=0, issued_cnt=0.
//  - start, 8 back-to-back ADDs, fetch_stall=0 -> 8 issued in order, issued_cnt=8,
//    16 NOP cycles, then done=1.
//  - FIFO fill: fetch_stall=1 for 10 cycles during RUN -> src_ready drops after 4 pushes;
//    out_inst held; order preserved after the stall releases.
//  - Source gaps: src_valid low 3 cycles mid-run -> 3 NOP bubbles,
//    issued_cnt unchanged during the gap.
//  - DRAIN with fetch_stall toggled every other cycle -> DONE after exactly 16 non-stalled cycles.
//  - With INST_LEGALITY_CHECK_EN: push 32'h00100F33 (rd=30) -> NOP issued,
//    illegal_seen=1, issued_cnt unchanged.

Source files
------------

// File: rtl/inst_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : inst_seq_pkg                                                    |
// | Shared constants, FSM state type and the instruction legality function.  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
package inst_seq_pkg;

  localparam logic [31:0] NOP_INST   = 32'h0000007F;

  localparam logic [6:0]  OPC_OP     = 7'h33;
  localparam logic [6:0]  OPC_OP_IMM = 7'h13;
  localparam logic [6:0]  OPC_LOAD   = 7'h03;
  localparam logic [6:0]  OPC_STORE  = 7'h23;
  localparam logic [6:0]  OPC_NOP    = 7'h7F;

  localparam logic [2:0]  F3_ADD     = 3'b000;
  localparam logic [2:0]  F3_SLL     = 3'b001;
  localparam logic [2:0]  F3_WORD    = 3'b010;
  localparam logic [2:0]  F3_SR      = 3'b101;

  localparam logic [6:0]  F7_BASE    = 7'h00;
  localparam logic [6:0]  F7_ALT     = 7'h20;
  localparam logic [6:0]  F7_MULDIV  = 7'h01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Supported subset: R-type ALU + MUL family, I-type ALU/shifts, LW/SW off x0
  // within the low 1 KiB, and the NOP opcode; only x0..x15 are usable.
  function automatic logic inst_is_legal(input logic [31:0] inst);
    logic [6:0] opc;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ok;
    opc = inst[6:0];
    rd  = inst[11:7];
    f3  = inst[14:12];
    rs1 = inst[19:15];
    rs2 = inst[24:20];
    f7  = inst[31:25];
    ok  = 1'b0;
    case (opc)
      OPC_OP:
        ok = !rd[4] && !rs1[4] && !rs2[4] &&
             ((f7 == F7_BASE) ||
              ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR))) ||
              ((f7 == F7_MULDIV) && !f3[2]));
      OPC_OP_IMM:
        ok = !rd[4] && !rs1[4] &&
             ((f3 == F3_SLL) ? (f7 == F7_BASE) :
              (f3 == F3_SR)  ? ((f7 == F7_BASE) || (f7 == F7_ALT)) : 1'b1);
      OPC_LOAD:
        ok = !rd[4] && (f3 == F3_WORD) && (rs1 == 5'd0) && (inst[31:30] == 2'b00);
      OPC_STORE:
        ok = !rs2[4] && (f3 == F3_WORD) && (rs1 == 5'd0) && (inst[31:30] == 2'b00);
      OPC_NOP:
        ok = 1'b1;
      default:
        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : inst_sequencer_if                                               |
// | Source handshake and core fetch signals of the instruction sequencer.    |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
interface inst_sequencer_if;
  logic        src_valid;
  logic [31:0] src_inst;
  logic        src_ready;
  logic        fetch_stall;
  logic        out_valid;
  logic [31:0] out_inst;

  modport master (
    output src_valid, src_inst, fetch_stall,
    input  src_ready, out_valid, out_inst
  );

  modport slave (
    input  src_valid, src_inst, fetch_stall,
    output src_ready, out_valid, out_inst
  );
endinterface
`default_nettype wire

// File: rtl/inst_seq_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : inst_seq_fifo                                                   |
// | DEPTH-entry synchronous FIFO with wrap-bit pointers and async reset.     |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module inst_seq_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty = (wr_ptr_q == rd_ptr_q);
    count = wr_ptr_q - rd_ptr_q;
    rdata = mem_q[rd_ptr_q[AW-1:0]];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only observed while non-empty.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end
endmodule
`default_nettype wire

// File: rtl/inst_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : inst_sequencer                                                  |
// | Bounded instruction feeder for the ridecore fetch port: buffers source   |
// | instructions, issues them under stall, then drains with NOPs.            |
// | Option : INST_LEGALITY_CHECK_EN swaps unsupported instructions for NOP.  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module inst_sequencer
  import inst_seq_pkg::*;
#(
  parameter  int DEPTH        = 4,
  parameter  int MAX_INSTS    = 8,
  parameter  int DRAIN_CYCLES = 16,
  localparam int CW           = $clog2(MAX_INSTS + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  inst_sequencer_if.slave bus,
  output logic [CW-1:0]   issued_cnt,
  output logic            busy,
  output logic            done
`ifdef INST_LEGALITY_CHECK_EN
  ,
  output logic            illegal_seen
`endif
);
  localparam int            AW         = $clog2(DEPTH);
  localparam int            DW         = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] MAX_C      = CW'(MAX_INSTS);
  localparam logic [DW-1:0] DRAIN_C    = DW'(DRAIN_CYCLES);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [AW:0]   ONE_ENTRY  = (AW + 1)'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] accepted_q, accepted_d;
  logic [CW-1:0] issued_q, issued_d;
  logic [DW-1:0] drain_q, drain_d;
`ifdef INST_LEGALITY_CHECK_EN
  logic          illegal_q, illegal_d;
`endif

  logic          in_run, src_ready, head_counted;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]   fifo_wdata, fifo_head;
  logic [AW:0]   fifo_count;

  // src_ready depends only on registered state, never on pop or fetch_stall.
  always_comb begin
    in_run    = (state_q == RUN);
    src_ready = in_run && !fifo_full && (accepted_q != MAX_C);
    fifo_push = bus.src_valid && src_ready;
    fifo_pop  = in_run && !fifo_empty && !bus.fetch_stall;
`ifdef INST_LEGALITY_CHECK_EN
    fifo_wdata   = inst_is_legal(bus.src_inst) ? bus.src_inst : NOP_INST;
    head_counted = (fifo_head != NOP_INST);
`else
    fifo_wdata   = bus.src_inst;
    head_counted = 1'b1;
`endif
  end

  inst_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    accepted_d = accepted_q;
    issued_d   = issued_q;
    drain_d    = drain_q;
`ifdef INST_LEGALITY_CHECK_EN
    illegal_d  = illegal_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          accepted_d = '0;
          issued_d   = '0;
          drain_d    = '0;
`ifdef INST_LEGALITY_CHECK_EN
          illegal_d  = 1'b0;
`endif
        end
      end
      RUN: begin
        if (fifo_push) accepted_d = accepted_q + 1'b1;
        if (fifo_pop && head_counted && (issued_q != MAX_C)) issued_d = issued_q + 1'b1;
`ifdef INST_LEGALITY_CHECK_EN
        if (fifo_push && !inst_is_legal(bus.src_inst)) illegal_d = 1'b1;
`endif
        // Leave once every accepted instruction has been handed to the core.
        if ((accepted_q == MAX_C) && (fifo_empty || ((fifo_count == ONE_ENTRY) && fifo_pop)))
          state_d = DRAIN;
      end
      DRAIN: begin
        if (!bus.fetch_stall) begin
          if (drain_q != DRAIN_C) drain_d = drain_q + 1'b1;
          if (drain_q >= DRAIN_LAST) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      accepted_q <= '0;
      issued_q   <= '0;
      drain_q    <= '0;
`ifdef INST_LEGALITY_CHECK_EN
      illegal_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      accepted_q <= accepted_d;
      issued_q   <= issued_d;
      drain_q    <= drain_d;
`ifdef INST_LEGALITY_CHECK_EN
      illegal_q  <= illegal_d;
`endif
    end
  end

  assign busy          = (state_q == RUN) || (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign issued_cnt    = issued_q;
  assign bus.src_ready = src_ready;
  assign bus.out_valid = busy;
  assign bus.out_inst  = (in_run && !fifo_empty) ? fifo_head : NOP_INST;
`ifdef INST_LEGALITY_CHECK_EN
  assign illegal_seen  = illegal_q;
`endif
endmodule
`default_nettype wire
